// File: rtl/tc0360pri_mix.sv
// tc0360pri_mix -- priority mixer for two tilemap layers and one sprite layer.
//
// Holds a 16 x 8-bit CPU register file and runs a 2-stage pixel pipeline
// that picks the highest-priority opaque layer and emits a palette index.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   ce_pixel                    pixel-rate enable for the pipeline
//   CS, MA, RWn, UDSn, LDSn     CPU bus control; MDin write data, MDout read data
//   DTACKn                      transfer acknowledge (one wait cycle)
//   HBLANKn_in/VBLANKn_in       blanking in; HBLANKn/VBLANKn delayed to match IM
//   BG0, BG1, SPR, SPR_GRP      layer colour indices and sprite priority group
//   IM                          {bank, colour index} of the winning layer
module tc0360pri_mix (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pixel,
   input  logic [15:0] MDin,
   output logic [15:0] MDout,
   input  logic        CS,
   input  logic [3:0]  MA,
   input  logic        RWn,
   input  logic        UDSn,
   input  logic        LDSn,
   output logic        DTACKn,
   input  logic        HBLANKn_in,
   input  logic        VBLANKn_in,
   output logic        HBLANKn,
   output logic        VBLANKn,
   input  logic [11:0] BG0,
   input  logic [11:0] BG1,
   input  logic [11:0] SPR,
   input  logic [1:0]  SPR_GRP,
   output logic [13:0] IM
);

   logic [7:0] regs [16];
   logic       armed;  // CS has been seen low since reset

   logic unused_ok;
   assign unused_ok = &{1'b0, UDSn, MDin[15:8]};

   // ---------------- CPU side ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
         regs[0] <= 8'h07;
      end else if (CS && !RWn && !LDSn) begin
         regs[MA] <= MDin[7:0];
      end
   end

   assign MDout = {8'h00, regs[MA]};

   // A CS held high across reset must drop once before it is acknowledged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed  <= 1'b0;
         DTACKn <= 1'b1;
      end else if (!CS) begin
         armed  <= 1'b1;
         DTACKn <= 1'b1;
      end else if (armed) begin
         DTACKn <= 1'b0;
      end
   end

   // ---------------- stage 1 inputs ----------------
   logic [3:0] spr_pri;
   always_comb begin
      case (SPR_GRP)
         2'd0:    spr_pri = regs[6][3:0];
         2'd1:    spr_pri = regs[6][7:4];
         2'd2:    spr_pri = regs[7][3:0];
         default: spr_pri = regs[7][7:4];
      endcase
   end

   logic [11:0] s1_idx0, s1_idx1, s1_idx2;
   logic [2:0]  s1_op;
   logic [3:0]  s1_pri0, s1_pri1, s1_pri2;
   logic [1:0]  s1_bank0, s1_bank1, s1_bank2, s1_bgbank;
   logic        s1_hb, s1_vb;

   // Banks are captured alongside the pixel so a register write between
   // ce_pixel pulses cannot retroactively change an in-flight pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_idx0 <= '0; s1_idx1 <= '0; s1_idx2 <= '0;
         s1_op   <= '0;
         s1_pri0 <= '0; s1_pri1 <= '0; s1_pri2 <= '0;
         s1_bank0 <= '0; s1_bank1 <= '0; s1_bank2 <= '0; s1_bgbank <= '0;
         s1_hb <= 1'b0; s1_vb <= 1'b0;
      end else if (ce_pixel) begin
         s1_idx0   <= BG0;
         s1_idx1   <= BG1;
         s1_idx2   <= SPR;
         s1_op     <= {regs[0][2] & (|SPR[3:0]),
                       regs[0][1] & (|BG1[3:0]),
                       regs[0][0] & (|BG0[3:0])};
         s1_pri0   <= regs[4][3:0];
         s1_pri1   <= regs[4][7:4];
         s1_pri2   <= spr_pri;
         s1_bank0  <= regs[2][1:0];
         s1_bank1  <= regs[2][3:2];
         s1_bank2  <= regs[2][5:4];
         s1_bgbank <= regs[2][7:6];
         s1_hb     <= HBLANKn_in;
         s1_vb     <= VBLANKn_in;
      end
   end

   // ---------------- stage 2 selection ----------------
   // Layers are visited in ascending tie precedence; >= lets a later layer
   // take an equal priority, giving SPR > BG1 > BG0 on ties.
   logic        found;
   logic [3:0]  win_pri;
   logic [13:0] win_im;
   always_comb begin
      found   = 1'b0;
      win_pri = 4'd0;
      win_im  = {s1_bgbank, 12'h000};
      if (s1_op[0]) begin
         found = 1'b1; win_pri = s1_pri0; win_im = {s1_bank0, s1_idx0};
      end
      if (s1_op[1] && (!found || s1_pri1 >= win_pri)) begin
         found = 1'b1; win_pri = s1_pri1; win_im = {s1_bank1, s1_idx1};
      end
      if (s1_op[2] && (!found || s1_pri2 >= win_pri)) begin
         found = 1'b1; win_pri = s1_pri2; win_im = {s1_bank2, s1_idx2};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IM      <= '0;
         HBLANKn <= 1'b0;
         VBLANKn <= 1'b0;
      end else if (ce_pixel) begin
         IM      <= win_im;
         HBLANKn <= s1_hb;
         VBLANKn <= s1_vb;
      end
   end

endmodule
